hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, number of cycles the older instructions need to leave EX/MEM/WB after a halt.
REQ-003 SHALL have ports: clock  in  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port instruccion_if_id  in  32  instruction in IF/ID: opcode [31:26], rs [25:21], rt [20:16].
REQ-006 SHALL have port MemRead_id_ex  in  1  the instruction in ID/EX is a load.
REQ-007 SHALL have port rt_id_ex  in  5  load destination register in ID/EX.
REQ-008 SHALL have port PCSrc_mem  in  1  taken branch resolved in MEM this cycle.
REQ-009 SHALL have port pc_write  out  1  PC register update enable.
REQ-010 SHALL have port if_id_write  out  1  IF/ID register update enable.
REQ-011 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  zero the control bits of that pipeline register.
REQ-012 SHALL have port halted  out  1  the pipeline is frozen.
REQ-013 SHALL have ports stall_count, flush_count  out  CNT_W each  saturating event counters.

Function
REQ-014 The block SHALL define uses_rt as true for opcode 000000 (R-type), 000100 (beq) and 101011 (sw).
REQ-015 The block SHALL define the load-use condition as: MemRead_id_ex=1, rt_id_ex!=0, and either rt_id_ex==rs, or uses_rt and rt_id_ex==rt.
REQ-016 The block SHALL have FSM states RUN, DRAIN and HALTED; reset SHALL put it in RUN.
REQ-017 Default outputs (no event) SHALL be: pc_write=1, if_id_write=1, all flushes=0.
REQ-018 Priority SHALL be PCSrc_mem > halt > load-use, evaluated combinationally in the same cycle.
REQ-019 On PCSrc_mem=1 in RUN or DRAIN: pc_write=1, if_id_flush=id_ex_flush=ex_mem_flush=1; flush_count+1; the FSM SHALL go to (or stay in) RUN, because a halt younger than the branch is squashed.
REQ-020 On load-use in RUN without PCSrc_mem or halt: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle (one bubble); stall_count+1.
REQ-021 Halt SHALL be opcode 111111 in IF/ID while in RUN without PCSrc_mem: pc_write=0, if_id_write=0, id_ex_flush=1; drain counter loaded with DRAIN_CYCLES-1; next state DRAIN.
REQ-022 In DRAIN: pc_write=0, if_id_write=0, id_ex_flush=1; counter decrements each cycle; at 0 with no PCSrc_mem, next state HALTED.
REQ-023 Load-use SHALL be ignored in DRAIN and HALTED.
REQ-024 In HALTED: pc_write=0, if_id_write=0, id_ex_flush=1, halted=1; PCSrc_mem ignored; exit only by reset.
REQ-025 halted SHALL be 0 in RUN and DRAIN.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 flush_count SHALL count taken branches in RUN and DRAIN only.

Reset
REQ-028 With reset=1 at a rising edge: state=RUN, drain counter=0, stall_count=0, flush_count=0.
REQ-029 Outputs SHALL take the RUN values combinationally from the next cycle onward.
REQ-030 Reset SHALL override every other input, including reset asserted mid-DRAIN or in HALTED.

Structure
REQ-031 Opcode constants (RTYPE, BEQ, SW, HALT) and FSM state encodings SHALL live in the shared pipeline package/include.
REQ-032 One sub-module sat_counter (CNT_W, inc, reset) SHALL be instantiated twice.
REQ-033 The block SHALL sit between instruction_fetch and instruction_decode at pipeline top level.

Verification
REQ-034 Scenario: MemRead_id_ex=1, rt_id_ex=5, IF/ID = add with rs=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1.
REQ-035 Scenario: rt_id_ex=0 with rs=0, then lw-in-IF/ID with rt=5 matching (uses_rt false) -> no stall either case.
REQ-036 Scenario: load-use and PCSrc_mem=1 in the same cycle -> pc_write=1, all three flushes=1, stall_count unchanged, flush_count=1.
REQ-037 Scenario: opcode 111111 in RUN -> 3 cycles halted=0 with freeze, then halted=1 held for 10 cycles even with PCSrc_mem=1.
REQ-038 Scenario: halt, then PCSrc_mem=1 on the 2nd DRAIN cycle -> state RUN, pc_write=1 next cycle, halted never 1.
REQ-039 Scenario: CNT_W=4 with 20 consecutive load-use cycles -> stall_count stays at 15; reset in HALTED -> all zero, state RUN.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: opcodes of interest to hazard detection and
// the hazard FSM state encoding.
package hazard_unit_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] HALT  = 6'b111111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == RTYPE) || (opcode == BEQ) || (opcode == SW);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
// One-cycle update latency; no backpressure, synchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes, halt/drain.
// Control outputs are combinational from IF/ID, ID/EX and MEM inputs plus FSM state.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruccion_if_id,
  input  logic             MemRead_id_ex,
  input  logic [4:0]       rt_id_ex,
  input  logic             PCSrc_mem,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hazard_state_t state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic [5:0]    opcode;
  logic [4:0]    rs, rt;
  logic          load_use;
  logic          stall_inc, flush_inc;

  assign opcode = instruccion_if_id[31:26];
  assign rs     = instruccion_if_id[25:21];
  assign rt     = instruccion_if_id[20:16];

  assign load_use = MemRead_id_ex && (rt_id_ex != 5'd0) &&
                    ((rt_id_ex == rs) || (uses_rt(opcode) && (rt_id_ex == rt)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state)
      RUN: begin
        if (PCSrc_mem) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
        end else if (opcode == HALT) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          drain_nxt   = DW'(DRAIN_CYCLES - 1);
          state_nxt   = DRAIN;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end
      end
      DRAIN: begin
        // A branch older than the halt squashes it and resumes fetching.
        if (PCSrc_mem) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
          state_nxt    = RUN;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (drain_cnt == '0) begin
            state_nxt = HALTED;
          end else begin
            drain_nxt = drain_cnt - 1'b1;
          end
        end
      end
      HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios then random traffic, compared
// against a cycle-level behavioural model; a 4-bit counter instance checks saturation.
module tb_hazard_unit;

  localparam int DC      = 3;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_read;
  logic [4:0]  rt_ex;
  logic        pcsrc;

  logic        a_pcw, a_ifw, a_iff, a_idf, a_emf, a_hlt;
  logic [15:0] a_stall, a_flush;
  logic        b_pcw, b_ifw, b_iff, b_idf, b_emf, b_hlt;
  logic [3:0]  b_stall, b_flush;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mode;
  int drain_left;
  int stalls;
  int flushes;

  always #5 clock = ~clock;

  hazard_unit #(.CNT_W(16), .DRAIN_CYCLES(DC)) u_dut (
    .clock(clock), .reset(reset), .instruccion_if_id(instr),
    .MemRead_id_ex(mem_read), .rt_id_ex(rt_ex), .PCSrc_mem(pcsrc),
    .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_iff),
    .id_ex_flush(a_idf), .ex_mem_flush(a_emf), .halted(a_hlt),
    .stall_count(a_stall), .flush_count(a_flush)
  );

  hazard_unit #(.CNT_W(4), .DRAIN_CYCLES(DC)) u_dut4 (
    .clock(clock), .reset(reset), .instruccion_if_id(instr),
    .MemRead_id_ex(mem_read), .rt_id_ex(rt_ex), .PCSrc_mem(pcsrc),
    .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_iff),
    .id_ex_flush(b_idf), .ex_mem_flush(b_emf), .halted(b_hlt),
    .stall_count(b_stall), .flush_count(b_flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One clock cycle: drive inputs, compare combinational outputs and the
  // counters against the model, then advance the model across the edge.
  task automatic step(input logic rst, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic mr, input logic [4:0] rte,
                      input logic pc);
    logic e_pcw, e_ifw, e_iff, e_idf, e_emf, e_hlt, lu;
    int s0, f0;
    reset    = rst;
    instr    = {op, rs, rt, 16'h0000};
    mem_read = mr;
    rt_ex    = rte;
    pcsrc    = pc;
    #1;
    s0 = stalls;
    f0 = flushes;
    e_pcw = 1'b1; e_ifw = 1'b1; e_iff = 1'b0; e_idf = 1'b0; e_emf = 1'b0; e_hlt = 1'b0;
    lu = mr && (rte != 0) &&
         ((rte == rs) || (((op == 6'd0) || (op == 6'd4) || (op == 6'd43)) && (rte == rt)));
    if (mode == M_HALT) begin
      e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1; e_hlt = 1'b1;
    end else if (pc) begin
      e_iff = 1'b1; e_idf = 1'b1; e_emf = 1'b1;
      flushes++;
      mode = M_RUN;
    end else if (mode == M_DRAIN) begin
      e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
      drain_left--;
      if (drain_left == 0) mode = M_HALT;
    end else if (op == 6'd63) begin
      e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
      mode = M_DRAIN;
      drain_left = DC;
    end else if (lu) begin
      e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
      stalls++;
    end
    if (!rst) begin
      check("pc_write",     {31'd0, a_pcw}, {31'd0, e_pcw});
      check("if_id_write",  {31'd0, a_ifw}, {31'd0, e_ifw});
      check("if_id_flush",  {31'd0, a_iff}, {31'd0, e_iff});
      check("id_ex_flush",  {31'd0, a_idf}, {31'd0, e_idf});
      check("ex_mem_flush", {31'd0, a_emf}, {31'd0, e_emf});
      check("halted",       {31'd0, a_hlt}, {31'd0, e_hlt});
      check("stall_count",  {16'd0, a_stall}, sat(s0, 65535));
      check("flush_count",  {16'd0, a_flush}, sat(f0, 65535));
      check("w4_pc_write",  {31'd0, b_pcw}, {31'd0, e_pcw});
      check("w4_halted",    {31'd0, b_hlt}, {31'd0, e_hlt});
      check("w4_stall",     {28'd0, b_stall}, sat(s0, 15));
      check("w4_flush",     {28'd0, b_flush}, sat(f0, 15));
    end else begin
      mode = M_RUN; drain_left = 0; stalls = 0; flushes = 0;
    end
    @(posedge clock);
    #1;
  endtask

  logic [5:0] op_tbl [6];

  initial begin
    op_tbl[0] = 6'd0;  op_tbl[1] = 6'd4;  op_tbl[2] = 6'd43;
    op_tbl[3] = 6'd35; op_tbl[4] = 6'd8;  op_tbl[5] = 6'd63;
    mode = M_RUN; drain_left = 0; stalls = 0; flushes = 0;

    step(1, 6'd8, 0, 0, 0, 0, 0);
    step(1, 6'd8, 0, 0, 0, 0, 0);
    step(0, 6'd8, 0, 0, 0, 0, 0);            // idle defaults, counters zero

    step(0, 6'd0, 5, 1, 1, 5, 0);            // add rs=5 behind lw r5
    step(0, 6'd0, 5, 1, 0, 5, 0);            // bubble gone, stall_count=1

    step(0, 6'd0, 0, 0, 1, 0, 0);            // r0 never hazards
    step(0, 6'd35, 1, 5, 1, 5, 0);           // lw rt is a destination
    step(0, 6'd0, 5, 0, 1, 5, 1);            // branch beats load-use
    step(0, 6'd8, 0, 0, 0, 0, 0);

    step(0, 6'd63, 5, 0, 0, 0, 0);           // halt enters drain
    for (int i = 0; i < 13; i++)
      step(0, 6'd63, 5, 0, 1, 5, (i >= DC) && (i % 2 == 1));
    step(1, 6'd8, 0, 0, 0, 0, 0);            // reset from HALTED
    step(0, 6'd8, 0, 0, 0, 0, 0);

    step(0, 6'd63, 0, 0, 0, 0, 0);           // halt, branch on 2nd drain cycle
    step(0, 6'd63, 0, 0, 0, 0, 0);
    step(0, 6'd63, 0, 0, 0, 0, 1);
    step(0, 6'd8, 0, 0, 0, 0, 0);
    step(0, 6'd8, 0, 0, 0, 0, 0);

    step(1, 6'd8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(0, 6'd0, 7, 0, 1, 7, 0);
    step(0, 6'd8, 0, 0, 0, 0, 0);            // 4-bit stall counter pinned at 15

    step(1, 6'd8, 0, 0, 0, 0, 0);
    step(0, 6'd63, 0, 0, 0, 0, 0);           // reset mid-drain
    step(1, 6'd8, 0, 0, 0, 0, 0);
    step(0, 6'd8, 0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      logic [5:0] rop;
      rop = op_tbl[$urandom_range(0, 4)];
      if ($urandom_range(0, 29) == 0) rop = 6'd63;
      step($urandom_range(0, 49) == 0, rop,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
